// File: rtl/down_counter_pkg.sv
// Shared types and defaults for the loadable down-counting timer.
package down_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage : down_counter_pkg

// File: rtl/counter_dec.sv
// Purely combinational WIDTH-bit decrementer, the counterpart of the up counter's incrementer.
module counter_dec #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH-1:0] o_diff_c
);

    assign o_diff_c = i_a - WIDTH'(1);

endmodule : counter_dec

// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with a valid/ready start handshake and a one-cycle done pulse.
// Define DOWN_COUNTER_TIMER_AUTO_RELOAD_EN for periodic operation (reload at terminal count).
module down_counter_timer
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_e           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_done;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_reload;
`endif

    logic [WIDTH-1:0] w_count_dec;
    logic             w_terminal;

    counter_dec #(
        .WIDTH (WIDTH)
    ) u_dec (
        .i_a      (r_count),
        .o_diff_c (w_count_dec)
    );

    // Treat 0 as terminal as well so the count can never wrap to all-ones.
    assign w_terminal = (r_count <= WIDTH'(1));

    // State, count and done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_done   <= 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
            r_reload <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load_valid) begin
                        if (load_value != '0) begin
                            r_count  <= load_value;
                            r_state  <= ST_RUN;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
                            r_reload <= load_value;
`endif
                        end else begin
                            r_count <= '0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end else if (enable) begin
                        if (w_terminal) begin
                            r_done  <= 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
                            r_count <= r_reload;
`else
                            r_count <= '0;
                            r_state <= ST_IDLE;
`endif
                        end else begin
                            r_count <= w_count_dec;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign count      = r_count;
    assign done       = r_done;
    assign busy       = (r_state == ST_RUN);
    assign load_ready = (r_state == ST_IDLE);

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer (one-shot, or auto-reload when the macro is defined).
module tb_down_counter_timer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset_n;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_value;
    logic         enable;
    logic         abort;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    down_counter_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .enable     (enable),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input int c, input bit b, input bit d);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".ready"}, 32'(load_ready), 32'(!b));
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load_valid = 1'b1;
        load_value = v;
        tick();
        load_valid = 1'b0;
    endtask

    initial begin
        int en_pat[5]  = '{1, 0, 0, 1, 1};
        int cnt_pat[5] = '{2, 2, 2, 1, 0};

        reset_n    = 1'b0;
        load_valid = 1'b1;
        load_value = 8'd7;
        enable     = 1'b1;
        abort      = 1'b0;

        // Reset with a load offered: nothing sampled.
        repeat (3) tick();
        expect_state("reset", 0, 1'b0, 1'b0);
        load_valid = 1'b0;
        reset_n    = 1'b1;
        tick();
        expect_state("post_release", 0, 1'b0, 1'b0);

        // Zero load: single done, busy never high.
        do_load(8'd0);
        expect_state("zero_load", 0, 1'b0, 1'b1);
        tick();
        expect_state("zero_load_after", 0, 1'b0, 1'b0);

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
        // Periodic done every 4 enabled cycles.
        do_load(8'd4);
        expect_state("ar_load", 4, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick(); expect_state("ar_3", 3, 1'b1, 1'b0);
            tick(); expect_state("ar_2", 2, 1'b1, 1'b0);
            tick(); expect_state("ar_1", 1, 1'b1, 1'b0);
            tick(); expect_state("ar_reload", 4, 1'b1, 1'b1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_state("ar_abort", 0, 1'b0, 1'b0);
        tick();
        expect_state("ar_abort_after", 0, 1'b0, 1'b0);
`else
        // One-shot 5: 5,4,3,2,1,0 with done on 0.
        do_load(8'd5);
        expect_state("os_load", 5, 1'b1, 1'b0);
        for (int i = 4; i >= 1; i--) begin
            tick();
            expect_state("os_run", i, 1'b1, 1'b0);
        end
        tick();
        expect_state("os_done", 0, 1'b0, 1'b1);
        tick();
        expect_state("os_after", 0, 1'b0, 1'b0);

        // Enable gating.
        enable = 1'b0;
        do_load(8'd3);
        expect_state("gate_load", 3, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            enable = 1'(en_pat[i]);
            tick();
            expect_state("gate_step", cnt_pat[i], (i != 4), (i == 4));
        end
        tick();
        expect_state("gate_after", 0, 1'b0, 1'b0);

        // Load ignored in RUN, then back-to-back reload in the done cycle.
        enable = 1'b1;
        do_load(8'd5);
        load_valid = 1'b1;
        load_value = 8'd9;
        tick();
        expect_state("run_ignore_4", 4, 1'b1, 1'b0);
        tick();
        expect_state("run_ignore_3", 3, 1'b1, 1'b0);
        load_valid = 1'b0;
        tick(); tick(); tick();
        expect_state("b2b_first_done", 0, 1'b0, 1'b1);
        do_load(8'd2);
        expect_state("b2b_load", 2, 1'b1, 1'b0);
        tick();
        expect_state("b2b_1", 1, 1'b1, 1'b0);
        tick();
        expect_state("b2b_done", 0, 1'b0, 1'b1);

        // Max value: done after 255 enabled cycles, no wrap.
        do_load(8'd255);
        expect_state("max_load", 255, 1'b1, 1'b0);
        repeat (254) tick();
        expect_state("max_1", 1, 1'b1, 1'b0);
        tick();
        expect_state("max_done", 0, 1'b0, 1'b1);
        tick();
        expect_state("max_nowrap", 0, 1'b0, 1'b0);
`endif

        // Abort mid-count.
        enable = 1'b1;
        do_load(8'd200);
        repeat (10) tick();
        expect_state("abort_pre", 190, 1'b1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_state("abort", 0, 1'b0, 1'b0);
        tick();
        expect_state("abort_after", 0, 1'b0, 1'b0);

        // Asynchronous reset mid-count.
        do_load(8'd200);
        repeat (10) tick();
        expect_state("rst_pre", 190, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        expect_state("rst_async", 0, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        expect_state("rst_after", 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_down_counter_timer
